// File: rtl/sha_msg_mem.sv
// Word-addressed message memory serving sha256 core read requests with a fixed-latency
// pipelined read path, a byte-enabled host write port and a self-clearing array.
module sha_msg_mem #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_addr_vld,
  input  logic [31:0]       mem_addr,
  output logic              mem_data_vld,
  output logic [31:0]       mem_data,
  output logic              mem_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic              clr,
  output logic              busy,
  output logic [31:0]       rd_count
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              bad;
  logic              hit;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic              pipe_vld  [RD_LAT];
  logic              pipe_err  [RD_LAT];
  logic [31:0]       pipe_data [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = READY;
      READY:   if (clr) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // Pointer wraps back to zero at the end of a sweep, so READY always holds ptr=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
    else if (clr)            ptr <= '0;
  end

  always_comb begin
    wr_word = mem[wr_addr];
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_be[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_en)     mem[wr_addr] <= wr_word;
  end

  assign idx = mem_addr[ADDR_W+1:2];
  assign bad = (|mem_addr[1:0]) || (|mem_addr[31:ADDR_W+2]) || (state == CLEAR);
  // Same-cycle write to the requested word is forwarded so the read sees the merged value.
  assign hit = wr_en && (state == READY) && (wr_addr == idx);
  assign rd_word = hit ? wr_word : mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_err[i]  <= 1'b0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= mem_addr_vld;
      pipe_err[0]  <= mem_addr_vld && bad;
      pipe_data[0] <= (mem_addr_vld && !bad) ? rd_word : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_err[i]  <= pipe_err[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign mem_data_vld = pipe_vld[RD_LAT-1];
  assign mem_err      = pipe_err[RD_LAT-1];
  assign mem_data     = pipe_data[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rd_count <= '0;
    else if (mem_addr_vld) rd_count <= rd_count + 32'd1;
  end

endmodule

// File: tb/tb_sha_msg_mem.sv
// Bench for sha_msg_mem: a timestamped response model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sha_msg_mem;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_addr_vld = 1'b0;
  logic [31:0]       mem_addr = '0;
  logic              mem_data_vld;
  logic [31:0]       mem_data;
  logic              mem_err;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [3:0]        wr_be = '0;
  logic              clr = 1'b0;
  logic              busy;
  logic [31:0]       rd_count;

  always #5 clk = ~clk;

  sha_msg_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
    .mem_data_vld(mem_data_vld), .mem_data(mem_data), .mem_err(mem_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr(clr), .busy(busy), .rd_count(rd_count)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: memory image, remaining clear cycles, and a queue of responses tagged with due cycle.
  typedef struct {
    longint      due;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0] m_mem [DEPTH];
  int          m_clear_left = DEPTH;
  logic [31:0] m_count = '0;
  longint      m_cyc = 0;
  resp_t       m_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic              was_busy;
    logic              bad;
    logic [ADDR_W-1:0] mi;
    if (!rst_n) begin
      m_q.delete();
      m_count = '0;
      m_clear_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_cyc++;
      was_busy = (m_clear_left > 0);
      if (!was_busy && wr_en)
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (mem_addr_vld) begin
        m_count = m_count + 32'd1;
        bad = was_busy || (mem_addr % 4 != 0) || (mem_addr >= DEPTH * 4);
        mi = ADDR_W'(mem_addr >> 2);
        m_q.push_back('{due: m_cyc + RD_LAT - 1, err: bad, data: bad ? 32'h0 : m_mem[mi]});
      end
      if (was_busy) m_clear_left--;
      else if (clr) begin
        m_clear_left = DEPTH;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    ev = 1'b0; ee = 1'b0; ed = '0;
    if (rst_n && m_q.size() > 0 && m_q[0].due == m_cyc) begin
      ev = 1'b1; ee = m_q[0].err; ed = m_q[0].data;
      void'(m_q.pop_front());
    end
    check("resp", {30'b0, mem_data_vld, mem_err, mem_data}, {30'b0, ev, ee, ed});
    check("busy", 64'(busy), 64'(m_clear_left > 0));
    check("rd_count", 64'(rd_count), 64'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    check("ready_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    mem_addr = a; mem_addr_vld = 1'b1;
    tick();
    mem_addr_vld = 1'b0; mem_addr = '0;
    for (int i = 1; i < RD_LAT; i++) begin
      check("rd_early_vld", 64'(mem_data_vld), 64'(0));
      tick();
    end
    check("rd_vld_at_lat", 64'(mem_data_vld), 64'(1));
    d = mem_data;
    e = mem_err;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          n;
    int          got;
    int          first_c;
    int          last_c;
    logic [31:0] d;
    logic        e;

    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'(1));
    check("reset_rd_count", 64'(rd_count), 64'(0));
    check("reset_vld", {31'b0, mem_data_vld, mem_data}, 64'(0));

    rst_n = 1'b1;
    wait_ready(n);
    check("clear_cycles", 64'(n), 64'(DEPTH));

    for (int i = 0; i < 64; i++) begin
      mem_addr = 32'(i * 4); mem_addr_vld = 1'b1;
      tick();
    end
    mem_addr_vld = 1'b0;
    repeat (RD_LAT + 1) tick();
    rd(32'h0000_00FC, d, e);
    check("zero_after_clear", {31'b0, e, d}, 64'(0));

    wr(6'd5, 32'h4141_4141, 4'hF);
    wr(6'd5, 32'h0000_BB00, 4'b0010);
    rd(32'h0000_0014, d, e);
    check("byte_enable_merge", {31'b0, e, d}, 64'h4141_BB41);
    wr(6'd5, 32'hFFFF_FFFF, 4'h0);
    rd(32'h0000_0014, d, e);
    check("be_zero_noop", {31'b0, e, d}, 64'h4141_BB41);

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n);
    for (int i = 0; i < 16; i++) wr(6'(i), 32'h1000 + 32'(i), 4'hF);
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16 + RD_LAT + 2; c++) begin
      if (c < 16) begin
        mem_addr = 32'(c * 4); mem_addr_vld = 1'b1;
      end else mem_addr_vld = 1'b0;
      tick();
      if (mem_data_vld === 1'b1) begin
        check("burst_data", {31'b0, mem_err, mem_data}, 64'(32'h1000 + 32'(got)));
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
    end
    check("burst_count", 64'(got), 64'(16));
    check("burst_first_latency", 64'(first_c), 64'(RD_LAT - 1));
    check("burst_contiguous", 64'(last_c - first_c), 64'(15));
    check("burst_rd_count", 64'(rd_count), 64'(16));

    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    mem_addr = 32'h0000_000C; mem_addr_vld = 1'b1;
    tick();
    wr_en = 1'b0; wr_be = '0; mem_addr_vld = 1'b0;
    repeat (RD_LAT - 1) tick();
    check("write_first", {31'b0, mem_data_vld, mem_err, mem_data}, {31'b0, 1'b1, 1'b0, 32'hDEAD_BEEF});
    rd(32'h0000_000D, d, e);
    check("misaligned", {31'b0, e, d}, {31'b0, 1'b1, 32'h0});
    rd(32'h0000_0100, d, e);
    check("out_of_range", {31'b0, e, d}, {31'b0, 1'b1, 32'h0});

    wr(6'd7, 32'hCAFE_F00D, 4'hF);
    mem_addr = 32'h0000_001C; mem_addr_vld = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    mem_addr_vld = 1'b0;
    repeat (RD_LAT - 2) tick();
    check("clr_inflight", {31'b0, mem_data_vld, mem_err, mem_data}, {31'b0, 1'b1, 1'b0, 32'hCAFE_F00D});
    tick();
    check("read_during_clear", {31'b0, mem_data_vld, mem_err, mem_data}, {31'b0, 1'b1, 1'b1, 32'h0});
    check("busy_after_clr", 64'(busy), 64'(1));
    wait_ready(n);
    check("clr_cycles", 64'(n), 64'(DEPTH - RD_LAT));
    rd(32'h0000_001C, d, e);
    check("cleared_word", {31'b0, e, d}, 64'(0));

    mem_addr = 32'h0000_0010; mem_addr_vld = 1'b1;
    tick();
    mem_addr = 32'h0000_0014;
    tick();
    mem_addr_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_drops_vld", 64'(mem_data_vld), 64'(0));
    for (int i = 0; i < RD_LAT + 2; i++) begin
      tick();
      check("no_resp_after_reset", 64'(mem_data_vld), 64'(0));
    end
    check("reset_rd_count2", 64'(rd_count), 64'(0));
    rst_n = 1'b1;
    repeat (20) tick();
    wr(6'd9, 32'hFFFF_FFFF, 4'hF);
    wait_ready(n);
    rd(32'h0000_0024, d, e);
    check("write_ignored_in_clear", {31'b0, e, d}, 64'(0));

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sha_msg_mem.md
Name: sha_msg_mem

Overview:
- Word-addressed message memory that answers the read requests the sha256 core issues on its mem_addr_vld/mem_addr interface.
- Replaces the fixed-pattern dummy RAM in the top level with real storage.
- A host write port loads message words; a fixed-latency, fully pipelined read path returns mem_data_vld/mem_data to the hash core.
- A clear state machine zeroes the array after reset and on request.

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, ≥2.
- ADDR_W, 6: word index width, equal to log2(DEPTH).
- RD_LAT, 2: request-to-response latency in cycles; ≥1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk by construction upstream.
- mem_addr_vld  in  1  read request strobe from the hash core.
- mem_addr  in  32  byte address of the requested word.
- mem_data_vld  out  1  read response strobe.
- mem_data  out  32  read response data.
- mem_err  out  1  response flag: misaligned, out-of-range, or issued during clear; qualified by mem_data_vld.
- wr_en  in  1  host write strobe.
- wr_addr  in  ADDR_W  host write word index.
- wr_data  in  32  host write data.
- wr_be  in  4  byte enables; bit i writes wr_data[8i+7:8i].
- clr  in  1  single-cycle pulse that requests a full-array clear.
- busy  out  1  high while clearing.
- rd_count  out  32  count of accepted read requests.

Behaviour:
- Reset (rst_n=0, asynchronous): mem_data_vld=0, mem_data=0, mem_err=0, busy=1, rd_count=0, read pipeline valid bits=0, state=CLEAR, clear pointer=0. Array contents are not reset; the clear FSM zeroes them.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to word[ptr], then ptr++. When ptr==DEPTH-1 is written, go to READY on the next cycle. busy=1 throughout CLEAR, so DEPTH cycles after reset release.
  - READY: busy=0. A clr pulse moves the FSM to CLEAR with ptr=0; clr while already in CLEAR is ignored and does not restart the pointer.
  - Host writes (wr_en) are ignored in CLEAR.
- Address decode: idx=mem_addr[ADDR_W+1:2]. A request is bad if mem_addr[1:0]!=0, or mem_addr[31:ADDR_W+2]!=0, or state==CLEAR.
- Read path:
  - Every cycle with mem_addr_vld=1 is accepted; there is no backpressure.
  - The response appears exactly RD_LAT cycles later: mem_data_vld=1 for one cycle, with mem_data=word[idx] and mem_err=0.
  - A bad request gives mem_data=0, mem_err=1.
  - Back-to-back requests produce back-to-back responses in order.
  - When mem_data_vld=0: mem_data=0 and mem_err=0.
- Write/read collision: a write and a read to the same idx in the same cycle returns the post-write merged word (write-first), honoring wr_be.
- Writes take effect at the clock edge. Byte lanes with wr_be=0 keep their prior value. wr_be=0 is a no-op.
- rd_count increments by 1 per accepted request, good or bad, and wraps 0xFFFFFFFF→0.
- clr in READY with reads in flight: responses already in the pipeline complete using the data sampled at request time. Requests issued from the cycle after the clr pulse onward are bad.
- Reset asserted mid-operation: all in-flight responses are discarded (no mem_data_vld), and the FSM re-enters CLEAR.

Test Plan:
- Release reset, hold no stimulus -> busy=1 for 64 cycles then 0. Read all 64 addresses 0x00..0xFC -> each returns 0x00000000, mem_err=0, 2 cycles after its request.
- Write idx 5 = 0x41414141 with wr_be=4'hF, then wr_be=4'b0010 with wr_data=0x0000BB00 -> read mem_addr=0x14 returns 0x4141BB41, mem_data_vld exactly 2 cycles after mem_addr_vld.
- Load idx 0..15 with 0x1000+i, then issue 16 back-to-back reads at 0x00..0x3C -> 16 consecutive valid responses 0x1000..0x100F in order; rd_count=16.
- In the same cycle, write idx 3=0xDEADBEEF and read mem_addr=0x0C -> response 0xDEADBEEF. Reads of 0x0D (misaligned) and 0x100 (out of range) -> mem_data=0, mem_err=1.
- With idx 7 holding 0xCAFEF00D:
  - Read 0x1C, and pulse clr in the same cycle -> response 0xCAFEF00D, mem_err=0.
  - Read issued in the next cycle -> mem_err=1.
  - After busy falls (64 cycles), read 0x1C -> 0x00000000.
- Assert rst_n=0 while 2 reads are in flight -> no mem_data_vld afterward, and rd_count=0. A write attempted during the subsequent CLEAR is ignored: the word reads 0 after busy=0.
